// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the shared RTC address/data bus: forwards the granted
// requester's strobes and byte through one register stage, enforces an idle gap and a watchdog.
module rtc_bus_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    output logic [2:0]  gnt,
    input  logic [2:0]  ad_in,
    input  logic [2:0]  wr_in,
    input  logic [2:0]  rd_in,
    input  logic [2:0]  cs_in,
    input  logic [23:0] dout_in,
    output logic [7:0]  ADout,
    output logic        ad,
    output logic        wr,
    output logic        rd,
    output logic        cs,
    output logic        ad_oe,
    output logic        busy,
    output logic        timeout,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [2:0] mask_q, mask_d;
    logic [7:0] wd_q, wd_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] dout_q, dout_d;
    logic       ad_q, ad_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       cs_q, cs_d;
    logic       oe_q, oe_d;
    logic       to_q, to_d;

    logic [2:0] elig;
    logic [1:0] pick;
    logic       pick_vld;

    logic       g_req;
    logic       g_ad;
    logic       g_wr;
    logic       g_rd;
    logic       g_cs;
    logic [7:0] g_dout;

    // (base + step) mod 3 for base in 0..2, step in 1..3
    function automatic logic [1:0] rot(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, step};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Masked requesters stay out until they drop req for at least one edge.
    always_comb begin
        elig     = req & ~mask_q;
        pick_vld = |elig;
        if (elig[rot(last_q, 2'd1)]) begin
            pick = rot(last_q, 2'd1);
        end else if (elig[rot(last_q, 2'd2)]) begin
            pick = rot(last_q, 2'd2);
        end else begin
            pick = rot(last_q, 2'd3);
        end
    end

    always_comb begin
        g_req  = req[0];
        g_ad   = ad_in[0];
        g_wr   = wr_in[0];
        g_rd   = rd_in[0];
        g_cs   = cs_in[0];
        g_dout = dout_in[7:0];
        case (last_q)
            2'd1: begin
                g_req  = req[1];
                g_ad   = ad_in[1];
                g_wr   = wr_in[1];
                g_rd   = rd_in[1];
                g_cs   = cs_in[1];
                g_dout = dout_in[15:8];
            end
            2'd2: begin
                g_req  = req[2];
                g_ad   = ad_in[2];
                g_wr   = wr_in[2];
                g_rd   = rd_in[2];
                g_cs   = cs_in[2];
                g_dout = dout_in[23:16];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        mask_d  = mask_q & req;
        to_d    = 1'b0;
        dout_d  = 8'hFF;
        ad_d    = 1'b1;
        wr_d    = 1'b1;
        rd_d    = 1'b1;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = 3'b001 << pick;
                    last_d  = pick;
                    wd_d    = 8'd0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A release on the watchdog edge wins: no pulse, no mask.
                if (!g_req || (wd_q == WD_LIMIT)) begin
                    gnt_d   = 3'b000;
                    gap_d   = 4'd0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    if (g_req) begin
                        to_d   = 1'b1;
                        mask_d = mask_d | gnt_q;
                    end
                end else begin
                    dout_d = g_dout;
                    ad_d   = g_ad;
                    wr_d   = g_wr;
                    rd_d   = g_rd;
                    cs_d   = g_cs;
                    oe_d   = g_rd;
                    wd_d   = wd_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
            mask_q  <= 3'b000;
            wd_q    <= 8'd0;
            gap_q   <= 4'd0;
            dout_q  <= 8'hFF;
            ad_q    <= 1'b1;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            cs_q    <= 1'b1;
            oe_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            dout_q  <= dout_d;
            ad_q    <= ad_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign ADout   = dout_q;
    assign ad      = ad_q;
    assign wr      = wr_q;
    assign rd      = rd_q;
    assign cs      = cs_q;
    assign ad_oe   = oe_q;
    assign timeout = to_q;
    assign busy    = (state_q != ST_IDLE);
    assign state   = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed and randomized bench for rtc_bus_arbiter against an edge-count
// reference model (grant/release edge numbers instead of an FSM).
module tb_rtc_bus_arbiter;

    localparam int GAP = 4;
    localparam int TO  = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  ad_in;
    logic [2:0]  wr_in;
    logic [2:0]  rd_in;
    logic [2:0]  cs_in;
    logic [23:0] dout_in;
    logic [7:0]  ADout;
    logic        ad;
    logic        wr;
    logic        rd;
    logic        cs;
    logic        ad_oe;
    logic        busy;
    logic        timeout;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index, edge numbers of last grant / release.
    int         m_owner;
    int         m_last;
    int         m_gedge;
    int         m_redge;
    int         edge_no;
    logic [2:0] m_block;
    logic [2:0] e_gnt;
    logic [7:0] e_dout;
    logic       e_ad;
    logic       e_wr;
    logic       e_rd;
    logic       e_cs;
    logic       e_oe;
    logic       e_to;

    logic [1:0] exp_q[$];

    rtc_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .ad_in   (ad_in),
        .wr_in   (wr_in),
        .rd_in   (rd_in),
        .cs_in   (cs_in),
        .dout_in (dout_in),
        .ADout   (ADout),
        .ad      (ad),
        .wr      (wr),
        .rd      (rd),
        .cs      (cs),
        .ad_oe   (ad_oe),
        .busy    (busy),
        .timeout (timeout),
        .state   (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic idle_pads();
        e_dout = 8'hFF;
        e_ad   = 1'b1;
        e_wr   = 1'b1;
        e_rd   = 1'b1;
        e_cs   = 1'b1;
        e_oe   = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 2;
        m_gedge = 0;
        m_redge = -1000;
        edge_no = 0;
        m_block = 3'b000;
        e_gnt   = 3'b000;
        e_to    = 1'b0;
        idle_pads();
    endtask

    task automatic end_grant();
        m_owner = -1;
        e_gnt   = 3'b000;
        m_redge = edge_no;
        idle_pads();
    endtask

    task automatic model_edge();
        bit found;
        edge_no++;
        e_to  = 1'b0;
        found = 0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                end_grant();
            end else if (edge_no - m_gedge == TO) begin
                m_block[m_owner] = 1'b1;
                e_to = 1'b1;
                end_grant();
            end else begin
                e_dout = dout_in[8*m_owner +: 8];
                e_ad   = ad_in[m_owner];
                e_wr   = wr_in[m_owner];
                e_rd   = rd_in[m_owner];
                e_cs   = cs_in[m_owner];
                e_oe   = rd_in[m_owner];
            end
        end else if (edge_no > m_redge + GAP) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (!found && req[idx] && !m_block[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_last  = idx;
                    m_gedge = edge_no;
                    e_gnt   = 3'(1 << idx);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!req[i]) m_block[i] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic e_busy;
        e_busy = (m_owner >= 0) || (edge_no < m_redge + GAP);
        chk({tag, ".gnt"}, gnt, e_gnt);
        chk({tag, ".ADout"}, ADout, e_dout);
        chk({tag, ".strobes"}, {ad, wr, rd, cs}, {e_ad, e_wr, e_rd, e_cs});
        chk({tag, ".ad_oe"}, ad_oe, e_oe);
        chk({tag, ".timeout"}, timeout, e_to);
        chk({tag, ".busy"}, busy, e_busy);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        ad_in   = 3'b111;
        wr_in   = 3'b111;
        rd_in   = 3'b111;
        cs_in   = 3'b111;
        dout_in = 24'hFFFFFF;
    endtask

    task automatic drain();
        req = 3'b000;
        idle_inputs();
        repeat (8) step("drain");
    endtask

    function automatic logic [1:0] gnt_index(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    initial begin
        logic [2:0] prev_g;
        int         zeros;
        int         seen;
        int         g1;
        int         tos;
        bit         flag;
        logic       v_ad;
        logic       v_cs;

        // Reset
        reset = 1'b1;
        req   = 3'b000;
        idle_inputs();
        model_reset();
        #1 reset = 1'b0;
        #1;
        check_outputs("reset");
        #2 reset = 1'b1;

        // Round-robin with all three requesting
        for (int k = 0; k < 6; k++) exp_q.push_back(2'(k % 3));
        req    = 3'b111;
        prev_g = 3'b000;
        zeros  = 0;
        seen   = 0;
        for (int c = 0; c < 300 && seen < 6; c++) begin
            step("rr");
            if (gnt != 3'b000 && prev_g == 3'b000) begin
                chk("rr_order", gnt_index(gnt), exp_q.pop_front());
                if (seen > 0) chk("rr_gap", zeros, 5);
                seen++;
                zeros = 0;
            end
            if (gnt == 3'b000) zeros++;
            prev_g = gnt;
            req = 3'b111;
            if (m_owner >= 0 && edge_no - m_gedge == 9) req[m_owner] = 1'b0;
        end
        chk("rr_count", seen, 6);
        drain();

        // Single request with tracked strobes
        repeat (5) step("sr_wait");
        req = 3'b001;
        step("sr_grant");
        chk("sr_gnt", gnt, 3'b001);
        for (int c = 0; c < 15; c++) begin
            v_ad        = 1'($urandom_range(0, 1));
            v_cs        = 1'($urandom_range(0, 1));
            ad_in[0]    = v_ad;
            cs_in[0]    = v_cs;
            wr_in[0]    = 1'($urandom_range(0, 1));
            rd_in[0]    = 1'($urandom_range(0, 1));
            dout_in[7:0] = 8'($urandom);
            step("sr_run");
            chk("sr_ad_track", ad, v_ad);
            chk("sr_cs_track", cs, v_cs);
        end
        idle_inputs();
        step("sr_high");
        req = 3'b000;
        step("sr_rel");
        chk("sr_rel_gnt", gnt, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            step("sr_gap");
            chk("sr_gap_ff", ADout, 8'hFF);
            chk("sr_gap_busy", busy, (k < 4) ? 1'b1 : 1'b0);
        end
        drain();

        // Watchdog on a stuck requester
        req = 3'b010;
        g1  = 0;
        tos = 0;
        for (int c = 0; c < 40; c++) begin
            step("wd");
            if (gnt == 3'b010) g1++;
            if (timeout) tos++;
        end
        chk("wd_hold", g1, TO);
        chk("wd_pulse", tos, 1);
        req = 3'b011;
        step("wd_r0");
        chk("wd_r0_gnt", gnt, 3'b001);
        repeat (5) step("wd_r0_run");
        req = 3'b010;
        g1  = 0;
        for (int c = 0; c < 10; c++) begin
            step("wd_masked");
            if (gnt[1]) g1++;
        end
        chk("wd_masked", g1, 0);
        req = 3'b000;
        step("wd_drop");
        req  = 3'b010;
        flag = 0;
        for (int c = 0; c < 10 && !flag; c++) begin
            step("wd_regrant");
            if (gnt == 3'b010) flag = 1;
        end
        chk("wd_regrant", flag, 1'b1);
        drain();

        // Isolation from a non-granted requester
        req     = 3'b001;
        dout_in = {8'h26, 8'hFF, 8'h24};
        cs_in   = 3'b110;
        step("iso_grant");
        cs_in[2] = ~cs_in[2];
        step("iso1");
        chk("iso_ad24", ADout, 8'h24);
        chk("iso_cs", cs, 1'b0);
        dout_in[7:0] = 8'h0A;
        cs_in[2] = ~cs_in[2];
        step("iso2");
        chk("iso_ad0a", ADout, 8'h0A);
        cs_in[2] = ~cs_in[2];
        step("iso3");
        chk("iso_ad0a_hold", ADout, 8'h0A);
        idle_inputs();
        step("iso_high");
        drain();

        // Reset in the middle of a transaction
        req          = 3'b001;
        cs_in        = 3'b110;
        wr_in        = 3'b110;
        dout_in[7:0] = 8'h55;
        repeat (3) step("rm");
        chk("rm_cs_low", cs, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rm_cs", cs, 1'b1);
        chk("rm_wr", wr, 1'b1);
        chk("rm_ADout", ADout, 8'hFF);
        chk("rm_gnt", gnt, 3'b000);
        chk("rm_ad_oe", ad_oe, 1'b0);
        chk("rm_busy", busy, 1'b0);
        model_reset();
        idle_inputs();
        req = 3'b110;
        #2 reset = 1'b1;
        step("rm_after");
        chk("rm_first_r1", gnt, 3'b010);
        drain();

        // Release on the watchdog edge
        req = 3'b100;
        step("se_grant");
        chk("se_gnt", gnt, 3'b100);
        repeat (TO - 1) step("se_run");
        req = 3'b000;
        step("se_rel");
        chk("se_no_pulse", timeout, 1'b0);
        chk("se_gnt_off", gnt, 3'b000);
        repeat (GAP) step("se_gap");
        req = 3'b100;
        step("se_regrant");
        chk("se_regrant", gnt, 3'b100);
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                end
            end
            ad_in   = 3'($urandom);
            wr_in   = 3'($urandom);
            rd_in   = 3'($urandom);
            cs_in   = 3'($urandom);
            dout_in = 24'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
